// File: rtl/debug_uart_pkg.sv
// rtl/debug_uart_pkg.sv - shared FSM encoding and bit-timing constants for the debug UART receiver
package debug_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  localparam int unsigned DATA_BITS        = 8;
  localparam int unsigned MIN_CLKS_PER_BIT = 4;

  function automatic int unsigned calc_clks_per_bit(input int unsigned clk_hz,
                                                    input int unsigned bit_rate);
    return clk_hz / bit_rate;
  endfunction

endpackage

// File: rtl/debug_uart_rx_fifo.sv
// rtl/debug_uart_rx_fifo.sv - synchronous receive FIFO with push/pop, full/empty and fill count
module debug_uart_rx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("debug_uart_rx_fifo: DEPTH must be a power of two >= 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/debug_uart_rx.sv
// rtl/debug_uart_rx.sv - 8N1 debug UART receiver with input synchronizer, FIFO and sticky error flags
module debug_uart_rx
  import debug_uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 24_000_000,
  parameter int unsigned BIT_RATE   = 4_000_000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          uart_rxd,
  input  logic                          rx_rd_en,
  input  logic                          err_clear,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          overrun,
  output logic                          frame_error,
  output logic                          rx_busy
);

  localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_HZ, BIT_RATE);
  localparam int unsigned CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LOAD  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD  = CW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < MIN_CLKS_PER_BIT) begin : g_bad_rate
    $error("debug_uart_rx: CLK_HZ/BIT_RATE must be at least 4");
  end

  logic            sync1_q, sync2_q;
  logic [1:0]      fill_q;
  logic            armed_q;
  logic            rxd_s;
  rx_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            push_byte, frame_evt, sample_now;
  logic            fifo_full, fifo_empty, pop_ok, ovf_evt;
  logic            overrun_q, frame_error_q;

  assign rxd_s = sync2_q;

  // fill_q marks when sync2_q holds a real line sample rather than its reset value;
  // armed_q then requires a genuinely idle line before the first start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      fill_q  <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= uart_rxd;
      sync2_q <= sync1_q;
      fill_q  <= {fill_q[0], 1'b1};
      armed_q <= armed_q | (fill_q[1] & sync2_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    case (state_q)
      ST_IDLE: begin
        if (armed_q && !rxd_s) begin
          state_d = ST_START;
          cnt_d   = HALF_LOAD;
        end
      end
      ST_START: begin
        if (cnt_q == '0) begin
          if (!rxd_s) begin
            state_d = ST_DATA;
            cnt_d   = FULL_LOAD;
            idx_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          shift_d[idx_q] = rxd_s;
          cnt_d          = FULL_LOAD;
          if (idx_q == 3'(DATA_BITS - 1)) state_d = ST_STOP;
          else                            idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == '0) state_d = rxd_s ? ST_IDLE : ST_BREAK;
        else             cnt_d   = cnt_q - 1'b1;
      end
      ST_BREAK: begin
        if (rxd_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sample_now = (cnt_q == '0);
    push_byte  = (state_q == ST_STOP) && sample_now && rxd_s;
    frame_evt  = (state_q == ST_STOP) && sample_now && !rxd_s;
    rx_busy    = (state_q != ST_IDLE);
  end

  debug_uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_byte),
    .data_i  (shift_q),
    .pop_i   (rx_rd_en),
    .data_o  (rx_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (rx_count)
  );

  assign rx_valid = !fifo_empty;
  assign pop_ok   = rx_rd_en && !fifo_empty;
  assign ovf_evt  = push_byte && fifo_full && !pop_ok;

  // A new error event in the same cycle as err_clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q     <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      if (ovf_evt)        overrun_q <= 1'b1;
      else if (err_clear) overrun_q <= 1'b0;
      if (frame_evt)      frame_error_q <= 1'b1;
      else if (err_clear) frame_error_q <= 1'b0;
    end
  end

  assign overrun     = overrun_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_debug_uart_rx.sv
// tb/tb_debug_uart_rx.sv - self-checking bench for debug_uart_rx against a byte-queue reference model
module tb_debug_uart_rx;

  localparam int CPB   = 6;
  localparam int DEPTH = 4;
  // Clock edges from the start-bit falling edge to the stop-bit sample:
  // two synchronizer stages, one idle detect, half a bit, then nine full bits.
  localparam int STOP_EDGE = 2 + 1 + CPB / 2 + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rxd = 1'b1;
  logic       rx_rd_en = 1'b0;
  logic       err_clear = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [2:0] rx_count;
  logic       overrun, frame_error, rx_busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] model_q[$];
  logic       m_ovr = 1'b0;
  logic       m_fe  = 1'b0;

  debug_uart_rx #(
    .CLK_HZ     (24_000_000),
    .BIT_RATE   (4_000_000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .uart_rxd    (uart_rxd),
    .rx_rd_en    (rx_rd_en),
    .err_clear   (err_clear),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_count    (rx_count),
    .overrun     (overrun),
    .frame_error (frame_error),
    .rx_busy     (rx_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_push(input logic [7:0] b);
    if (model_q.size() < DEPTH) model_q.push_back(b);
    else m_ovr = 1'b1;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_count"}, 32'(rx_count), 32'(model_q.size()));
    chk({tag, "_valid"}, 32'(rx_valid), 32'(model_q.size() > 0));
    if (model_q.size() > 0) chk({tag, "_data"}, 32'(rx_data), 32'(model_q[0]));
    chk({tag, "_ovr"}, 32'(overrun), 32'(m_ovr));
    chk({tag, "_fe"}, 32'(frame_error), 32'(m_fe));
  endtask

  // Frame starts at the first negedge; with stop_b=0 the line is left low.
  task automatic send_byte(input logic [7:0] b, input logic stop_b);
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rxd = stop_b;
    repeat (CPB) @(negedge clk);
    if (stop_b) uart_rxd = 1'b1;
  endtask

  // Same frame, with rx_rd_en or err_clear held high across the stop-bit sample edge.
  task automatic send_pulse(input logic [7:0] b, input logic stop_b, input bit use_clear);
    fork
      send_byte(b, stop_b);
      begin
        @(negedge clk);
        repeat (STOP_EDGE - 1) @(posedge clk);
        @(negedge clk);
        if (use_clear) err_clear = 1'b1;
        else           rx_rd_en  = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        rx_rd_en  = 1'b0;
      end
    join
  endtask

  task automatic pop_one();
    @(negedge clk);
    rx_rd_en = 1'b1;
    @(negedge clk);
    rx_rd_en = 1'b0;
    if (model_q.size() > 0) void'(model_q.pop_front());
  endtask

  task automatic clear_errs();
    @(negedge clk);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    m_ovr = 1'b0;
    m_fe  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(rx_valid), 0);
    chk({tag, "_count"}, 32'(rx_count), 0);
    chk({tag, "_data"}, 32'(rx_data), 0);
    chk({tag, "_ovr"}, 32'(overrun), 0);
    chk({tag, "_fe"}, 32'(frame_error), 0);
    chk({tag, "_busy"}, 32'(rx_busy), 0);
  endtask

  initial begin
    logic [7:0] b;
    int         n;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (5) @(negedge clk);

    send_byte(8'hA5, 1'b1);
    model_push(8'hA5);
    check_state("a5");
    pop_one();
    check_state("a5_pop");

    for (int i = 1; i <= 5; i++) begin
      send_byte(8'(i), 1'b1);
      model_push(8'(i));
    end
    check_state("fill5");
    for (int i = 0; i < DEPTH; i++) begin
      check_state($sformatf("drain%0d", i));
      pop_one();
    end
    check_state("drained");
    pop_one();
    check_state("pop_empty");
    clear_errs();
    check_state("ovr_clear");

    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (2) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (10) @(negedge clk);
    chk("glitch_busy", 32'(rx_busy), 0);
    check_state("glitch");

    send_pulse(8'h3C, 1'b0, 1'b1);
    m_fe = 1'b1;
    repeat (20) @(negedge clk);
    chk("break_busy", 32'(rx_busy), 1);
    check_state("break");
    uart_rxd = 1'b1;
    repeat (5) @(negedge clk);
    chk("break_exit_busy", 32'(rx_busy), 0);
    clear_errs();
    send_byte(8'h55, 1'b1);
    model_push(8'h55);
    check_state("after_break");
    pop_one();

    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      send_byte(b, 1'b1);
      model_push(b);
    end
    check_state("full4");
    send_pulse(8'h77, 1'b1, 1'b0);
    void'(model_q.pop_front());
    model_push(8'h77);
    check_state("full_pushpop");
    for (int i = 0; i < DEPTH; i++) begin
      check_state($sformatf("pp_drain%0d", i));
      pop_one();
    end
    check_state("pp_empty");

    for (int it = 0; it < 16; it++) begin
      b = 8'($urandom);
      send_byte(b, 1'b1);
      model_push(b);
      check_state($sformatf("rnd%0d", it));
      n = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) begin
        pop_one();
        check_state($sformatf("rnd%0d_pop%0d", it, k));
      end
    end

    send_byte(8'h11, 1'b1);
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      b = 8'h96;
      uart_rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    rst = 1'b0;
    model_q.delete();
    m_ovr = 1'b0;
    m_fe  = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrst_low_busy", 32'(rx_busy), 0);
    uart_rxd = 1'b1;
    repeat (12) @(negedge clk);
    check_state("midrst_idle");
    send_byte(8'hC3, 1'b1);
    model_push(8'hC3);
    check_state("c3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/debug_uart_rx.md
DEBUG_UART_RX -- requirements
Module: debug_uart_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 24_000_000: system clock frequency in Hz.
REQ-002 SHALL have parameter BIT_RATE, default 4_000_000: serial bit rate; CLKS_PER_BIT = CLK_HZ/BIT_RATE (integer, 6 at defaults).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: receive FIFO entries, power of two.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 uart_rxd  input  1  asynchronous serial input, idle high, 8N1, LSB first.
REQ-007 rx_rd_en  input  1  pop FIFO head this cycle.
REQ-008 err_clear  input  1  clear sticky error flags this cycle.
REQ-009 rx_data  output  8  FIFO head byte; valid only when rx_valid=1.
REQ-010 rx_valid  output  1  FIFO not empty.
REQ-011 rx_count  output  $clog2(FIFO_DEPTH)+1  bytes currently held.
REQ-012 overrun  output  1  sticky: a byte was dropped because the FIFO was full.
REQ-013 frame_error  output  1  sticky: a stop bit sampled low.
REQ-014 rx_busy  output  1  receiver FSM not in IDLE.

Function
REQ-015 uart_rxd SHALL pass through a 2-flop synchronizer; all FSM decisions use the synchronized value.
REQ-016 FSM states SHALL be IDLE, START, DATA, STOP, BREAK.
REQ-017 IDLE: on synchronized rxd = 0, go to START, load bit counter with CLKS_PER_BIT/2 - 1.
REQ-018 START: at counter zero sample rxd; 0 -> DATA with counter CLKS_PER_BIT-1, bit index 0; 1 -> IDLE (glitch, no flag, nothing pushed).
REQ-019 DATA: at each counter zero shift sampled rxd into bit[index], reload CLKS_PER_BIT-1; after index 7 go to STOP.
REQ-020 STOP: at counter zero sample rxd; 1 -> push byte, IDLE; 0 -> set frame_error, discard byte, BREAK.
REQ-021 BREAK: remain until synchronized rxd = 1, then IDLE.
REQ-022 Pushed byte SHALL appear on rx_data/rx_valid the cycle after the stop-bit sample.
REQ-023 rx_data SHALL always present the oldest unread byte; rx_rd_en with rx_valid=1 advances to next byte next cycle.
REQ-024 rx_rd_en with FIFO empty SHALL be ignored (no pointer or count change).
REQ-025 Push with FIFO full and no simultaneous pop SHALL discard the new byte and set overrun; FIFO contents unchanged.
REQ-026 Simultaneous push and pop when full SHALL succeed: count unchanged, no overrun.
REQ-027 Simultaneous push and pop when empty SHALL push; rx_valid=1 next cycle, count 1.
REQ-028 Pointers SHALL wrap modulo FIFO_DEPTH; count SHALL never exceed FIFO_DEPTH nor underflow.
REQ-029 err_clear SHALL clear both flags; a same-cycle new error event SHALL win (flag stays set).
REQ-030 rx_busy SHALL be 1 in every state except IDLE.

Reset
REQ-031 rst SHALL force FSM to IDLE, FIFO empty (rx_valid=0, rx_count=0), rx_data=0, overrun=0, frame_error=0, rx_busy=0.
REQ-032 Synchronizer flops SHALL reset to 1 (idle line).
REQ-033 Reset mid-frame SHALL abandon the partial byte; after release the receiver SHALL wait for line idle-then-low before a new frame.

Structure
REQ-034 Package debug_uart_pkg SHALL hold FSM state encoding and CLKS_PER_BIT derivation constants.
REQ-035 One sub-module debug_uart_rx_fifo (synchronous FIFO, push/pop/full/empty/count) SHALL be instantiated; the FSM stays in debug_uart_rx.
REQ-036 Elaboration SHALL fail if CLKS_PER_BIT < 4.

Verification (CLK_HZ=24e6, BIT_RATE=4e6)
REQ-037 Send 0xA5 8N1 at 6 clk/bit -> rx_valid rises, rx_data=0xA5, rx_count=1, no flags.
REQ-038 Send 0x01..0x05 without reads -> FIFO holds 0x01..0x04, overrun=1; four pops return 0x01..0x04 in order, then rx_valid=0.
REQ-039 Send 0x3C with stop bit low, line held low 20 clk -> frame_error=1, rx_count=0, rx_busy=1 until line high; next 0x55 received correctly.
REQ-040 2-clk low glitch on idle line -> returns to IDLE, nothing pushed, no flags.
REQ-041 FIFO full, pop in same cycle as stop-bit push of 0x77 -> count stays 4, overrun=0, 0x77 last in order.
REQ-042 Assert rst mid-byte (after bit 3) -> all outputs 0 next cycle; following 0xC3 received intact.
